// File: rtl/sram_pkg.sv
// Shared helpers for the parametrised 1RW+1R SRAM model: lane count,
// collision counter width and the masked lane merge used for writes and bypass.
package sram_pkg;

    localparam int COLL_CNT_W  = 16;
    // Widest word (or lane-parity vector) the merge helper can handle.
    localparam int MERGE_MAX_W = 512;

    function automatic int num_lanes(input int dw, input int lw);
        return dw / lw;
    endfunction

    // Bit b takes new_word when the mask bit of its lane (b / lw) is set.
    function automatic logic [MERGE_MAX_W-1:0] lane_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] mask,
        input int                     lw
    );
        logic [MERGE_MAX_W-1:0] res;
        res = old_word;
        for (int b = 0; b < MERGE_MAX_W; b++) begin
            if (mask[b / lw]) res[b] = new_word[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read data + valid delay line; dout holds the last completed read.
module sram_rd_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data
);

    logic [RD_LATENCY-1:0] vld_pipe;
    logic [DATA_WIDTH-1:0] dat_pipe [RD_LATENCY];

    // Each stage only loads when a valid word moves into it, so the last
    // stage keeps its value between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat_pipe[i] <= '0;
        end else begin
            vld_pipe[0] <= in_vld;
            if (in_vld) dat_pipe[0] <= in_data;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
            end
        end
    end

    assign out_vld  = vld_pipe[RD_LATENCY-1];
    assign out_data = dat_pipe[RD_LATENCY-1];

endmodule

// File: rtl/sram_1rw1r_param.sv
// Parametrised 1RW+1R single-clock SRAM model with collision bypass/counting.
// Define SRAM_PARITY_EN to add per-lane even parity storage and checking.
module sram_1rw1r_param
    import sram_pkg::*;
#(
    parameter  int DATA_WIDTH  = 32,
    parameter  int ADDR_WIDTH  = 10,
    parameter  int LANE_WIDTH  = 8,
    parameter  int RD_LATENCY  = 1,
    parameter  int WRITE_FIRST = 1,
    localparam int NUM_LANES   = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_LANES-1:0]  wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_vld,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_vld,
`ifdef SRAM_PARITY_EN
    input  logic                  par_inj0,
    output logic [NUM_LANES-1:0]  parity_err,
`endif
    output logic                  collision,
    output logic [COLL_CNT_W-1:0] coll_cnt
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef SRAM_PARITY_EN
    localparam int PIPE_W = DATA_WIDTH + NUM_LANES;
`else
    localparam int PIPE_W = DATA_WIDTH;
`endif

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_lat
        $error("sram_1rw1r_param: RD_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH % LANE_WIDTH != 0 || DATA_WIDTH >= MERGE_MAX_W) begin : g_bad_width
        $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of LANE_WIDTH and below MERGE_MAX_W");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic rd0, wr0, rd1, coll_now;
    assign rd0      = !csb0 && web0;
    assign wr0      = !csb0 && !web0 && (|wmask0);
    assign rd1      = !csb1;
    assign coll_now = wr0 && rd1 && (addr0 == addr1);

    logic [MERGE_MAX_W-1:0] wr_full;
    logic [DATA_WIDTH-1:0]  wr_word;
    assign wr_full = lane_merge(MERGE_MAX_W'(mem[addr0]), MERGE_MAX_W'(din0),
                                MERGE_MAX_W'(wmask0), LANE_WIDTH);
    assign wr_word = wr_full[DATA_WIDTH-1:0];

    // Array is deliberately not reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (rst_n && wr0) mem[addr0] <= wr_word;
    end

    logic [DATA_WIDTH-1:0] rd1_word;
    assign rd1_word = (coll_now && WRITE_FIRST != 0) ? wr_word : mem[addr1];

    logic [PIPE_W-1:0] rd0_pipe_in, rd1_pipe_in, p0_data, p1_data;

`ifdef SRAM_PARITY_EN
    logic [NUM_LANES-1:0]   par_mem [DEPTH];
    logic [NUM_LANES-1:0]   new_par, par_word, err0, err1;
    logic [MERGE_MAX_W-1:0] par_full;

    always_comb begin
        new_par = '0;
        for (int i = 0; i < NUM_LANES; i++) new_par[i] = ^din0[i*LANE_WIDTH +: LANE_WIDTH];
        new_par[0] = new_par[0] ^ par_inj0;
    end

    // Lane width 1 turns the word merge into a per-lane parity merge.
    assign par_full = lane_merge(MERGE_MAX_W'(par_mem[addr0]), MERGE_MAX_W'(new_par),
                                 MERGE_MAX_W'(wmask0), 1);
    assign par_word = par_full[NUM_LANES-1:0];

    always_ff @(posedge clk) begin
        if (rst_n && wr0) par_mem[addr0] <= par_word;
    end

    assign rd0_pipe_in = {par_mem[addr0], mem[addr0]};
    assign rd1_pipe_in = (coll_now && WRITE_FIRST != 0) ? {par_word, wr_word}
                                                        : {par_mem[addr1], mem[addr1]};

    always_comb begin
        err0 = '0;
        err1 = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            err0[i] = (^p0_data[i*LANE_WIDTH +: LANE_WIDTH]) ^ p0_data[DATA_WIDTH+i];
            err1[i] = (^p1_data[i*LANE_WIDTH +: LANE_WIDTH]) ^ p1_data[DATA_WIDTH+i];
        end
    end

    assign parity_err = ({NUM_LANES{dout0_vld}} & err0) | ({NUM_LANES{dout1_vld}} & err1);

    logic merge_unused;
    assign merge_unused = &{1'b0, wr_full[MERGE_MAX_W-1:DATA_WIDTH], par_full[MERGE_MAX_W-1:NUM_LANES]};
`else
    assign rd0_pipe_in = mem[addr0];
    assign rd1_pipe_in = rd1_word;

    logic merge_unused;
    assign merge_unused = &{1'b0, wr_full[MERGE_MAX_W-1:DATA_WIDTH], rd1_word};
`endif

    sram_rd_pipe #(.DATA_WIDTH(PIPE_W), .RD_LATENCY(RD_LATENCY)) u_pipe0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd0),
        .in_data  (rd0_pipe_in),
        .out_vld  (dout0_vld),
        .out_data (p0_data)
    );

    sram_rd_pipe #(.DATA_WIDTH(PIPE_W), .RD_LATENCY(RD_LATENCY)) u_pipe1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (rd1),
        .in_data  (rd1_pipe_in),
        .out_vld  (dout1_vld),
        .out_data (p1_data)
    );

    assign dout0 = p0_data[DATA_WIDTH-1:0];
    assign dout1 = p1_data[DATA_WIDTH-1:0];

    // Collision flag is one register deep whatever the read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision <= 1'b0;
            coll_cnt  <= '0;
        end else begin
            collision <= coll_now;
            if (coll_now && coll_cnt != '1) coll_cnt <= coll_cnt + 1'b1;
        end
    end

endmodule
